border_cropper: RTL and testbench
=================================

# border_cropper

Removes the symmetric-extension border from each line after the DWT 9/7 lifting stages. Consumes a line-framed AXI-Stream of sample pairs and drops the first `CropSize` and last `CropSize` beats of every line. It re-tags `sof` and `eol` on the first and last surviving beats. It sits at the output of the row/column lifting pipeline, mirroring the border expander at its input.

## Interface
- `DataWidth`, 16: width of one sample; each beat carries 2 samples.
- `CropSize`, 4: beats dropped at each line end; must match the expander's extension size.
- `EnableInputReg`, 1: 1 inserts a registered AXIS stage on the input; 0 makes it transparent.
- `clk_i` in 1: single clock; all logic on rising edge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `s_ready_o` out 1: input ready.
- `s_valid_i` in 1: input valid.
- `s_sof_i` in 1: start of frame; meaningful on the first beat of a line only.
- `s_eol_i` in 1: last beat of the input (expanded) line.
- `s_data_i` in `2*DataWidth`: input sample pair.
- `m_ready_i` in 1: output ready.
- `m_valid_o` out 1: output valid.
- `m_sof_o` out 1: start of frame, on the first surviving beat.
- `m_eol_o` out 1: last surviving beat of the line.
- `m_data_o` out `2*DataWidth`: output sample pair.
- `short_line_o` out 1: one-cycle pulse when a line is too short (see Configuration).

## Operation
- An internal beat counter `cnt` (0..`2*CropSize`) drives three states.
- A delay line of depth `CropSize` holds the most recent kept beats.
- **DropLeft** (`cnt < CropSize`):
  - `s_ready` = 1 and `m_valid` = 0.
  - Each accepted beat is discarded and increments `cnt`.
  - On the first beat of a line (`cnt` = 0), `s_sof` is latched into `need_sof`.
  - At `cnt = CropSize-1` with a handshake, go to Fill.
- **Fill** (`CropSize <= cnt < 2*CropSize`):
  - `s_ready` = 1 and `m_valid` = 0.
  - Each accepted beat is pushed into the delay line and increments `cnt`.
  - After the `CropSize`-th push, go to Stream.
- **Stream**:
  - Joint handshake: `s_ready = m_ready` and `m_valid = s_valid`.
  - Each transfer pushes the input beat and emits the oldest delay-line beat.
  - `m_sof = need_sof`; it clears after the first output transfer of the line.
  - `m_eol = s_eol`: the beat emitted alongside the input `eol` beat is the last kept beat.
  - On that `eol` transfer, clear `cnt` and the delay-line occupancy and go to DropLeft. The `CropSize` buffered beats (right border) are discarded.
- **Short line**: `s_eol` accepted in DropLeft or Fill.
  - Nothing is emitted for the line.
  - `cnt` clears and the state returns to DropLeft.
  - `short_line_o` pulses.
- **Line length**:
  - Minimum legal input line is `2*CropSize+1` beats.
  - Output length is input length minus `2*CropSize`.
- **Flag handling**:
  - `s_sof` on any beat other than the first of a line is ignored.
  - Data passes bit-exact; there is no arithmetic.

## Timing
- **Reset values**: `m_valid_o`=0, `m_sof_o`=0, `m_eol_o`=0, `m_data_o`=0, `short_line_o`=0. State is DropLeft with `cnt`=0 and `need_sof`=0.
- `s_ready_o`=1 on the first cycle after reset release.
- **Latency**:
  - Output register always present; input register present when `EnableInputReg`=1.
  - First output beat: `2*CropSize` accepted beats after line start, plus 1 cycle per enabled register stage.
- **Throughput**:
  - 1 beat/cycle in all states.
  - DropLeft and Fill never depend on `m_ready_i`.
- **Back-to-back lines**: the next line's first beat is accepted in the cycle after the `eol` transfer, with no bubble.
- **Stalls**: no beat is lost or duplicated under arbitrary `s_valid_i`/`m_ready_i` patterns.
- **Reset mid-line**: all buffered beats are dropped and no partial `eol` is emitted; the next line is processed normally.

## Configuration
- Macro `BORDER_CROPPER_SHORT_LINE_DET_EN`.
- **Defined**: short-line detection is built, and `short_line_o` pulses high for exactly one cycle on the clock edge after a short `eol` is accepted.
- **Undefined**: detection logic is omitted and `short_line_o` is tied to 0. Short lines still produce no output and still resynchronise to DropLeft.

## Structure
- Shared package `dwt97_pkg`:
  - `axis_t` packed struct (`sof`, `eol`, `data`).
  - `crop_state_t` enum (DropLeft, Fill, Stream).
  - Constant `ExpandSize = 4`, which is the default for `CropSize`.
- Reused existing sub-module `ShiftRegAddr` (width `2*DataWidth`, depth `CropSize`) as the delay line, read at fixed address `CropSize-1`.
- Existing `AxisReg` instances form the input stage (transparent when `EnableInputReg`=0) and the output stage.

## Test plan
- **Basic line**: 16 beats, data 0..15, `sof` on 0, `eol` on 15, `m_ready`=1 -> 8 beats, data 4..11, `sof` on 4, `eol` on 11.
- **Backpressure**: same line with `m_ready` toggling 1,0,1,0 and random `s_valid` gaps -> identical output 4..11; `s_ready_o` deasserts only in Stream.
- **Minimum line**: 9 beats, data 0..8 -> a single beat with data 4, `sof`=1 and `eol`=1.
- **Short line then recovery**: 6-beat line -> no output, one `short_line_o` pulse with the macro defined. Then a 12-beat line 100..111 -> 104..107 with `eol` on 107.
- **Back-to-back lines**: two 16-beat lines with no idle cycle, `sof` only on line 1 -> both lines are cropped correctly; `m_sof_o`=1 only on line 1's first output.
- **Reset mid-line**: `rst_ni` low for 1 cycle after 7 beats of a line -> `m_valid_o`=0 after reset; the next full 16-beat line yields 4..11.

Source files
------------

// File: rtl/dwt97_pkg.sv
// Shared types and constants for the DWT 9/7 line pipeline.
//   ExpandSize  : border extension applied by the expander, removed by the cropper
//   SampleWidth : default width of one sample (a beat carries two)
//   axis_t      : one line-framed stream beat at the default width
//   crop_state_t: border cropper phases
package dwt97_pkg;

    localparam int unsigned ExpandSize  = 4;
    localparam int unsigned SampleWidth = 16;

    typedef struct packed {
        logic                       sof;
        logic                       eol;
        logic [2*SampleWidth-1:0]   data;
    } axis_t;

    typedef enum logic [1:0] {
        DropLeft = 2'd0,
        Fill     = 2'd1,
        Stream   = 2'd2
    } crop_state_t;

endpackage

// File: rtl/border_cropper_if.sv
// Line-framed AXI-Stream link carrying one sample pair per beat.
//   valid/ready : handshake
//   sof         : start of frame (first beat of a line)
//   eol         : last beat of a line
//   data        : sample pair, 2*DataWidth bits
interface border_cropper_if #(
    parameter int unsigned DataWidth = 16
) ();

    logic                     valid;
    logic                     ready;
    logic                     sof;
    logic                     eol;
    logic [2*DataWidth-1:0]   data;

    modport master (output valid, output sof, output eol, output data, input ready);
    modport slave  (input valid, input sof, input eol, input data, output ready);

endinterface

// File: rtl/AxisReg.sv
// Single-entry AXI-Stream pipeline register with full throughput.
//   Enable=1: registered valid/data, ready = !full || downstream ready
//   Enable=0: wires straight through
// Ports: clk_i, rst_ni (sync, active-low), s_valid_i/s_ready_o/s_data_i upstream,
//        m_valid_o/m_ready_i/m_data_o downstream.
module AxisReg #(
    parameter int unsigned Width  = 34,
    parameter bit          Enable = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [Width-1:0]  s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [Width-1:0]  m_data_o
);

    if (Enable) begin : g_reg
        logic             valid_q;
        logic [Width-1:0] data_q;

        // Accept whenever empty or draining in the same cycle.
        assign s_ready_o = !valid_q || m_ready_i;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (s_ready_o) begin
                valid_q <= s_valid_i;
                if (s_valid_i) begin
                    data_q <= s_data_i;
                end
            end
        end

        assign m_valid_o = valid_q;
        assign m_data_o  = data_q;
    end else begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;

        assign s_ready_o = m_ready_i;
        assign m_valid_o = s_valid_i;
        assign m_data_o  = s_data_i;
    end

endmodule

// File: rtl/ShiftRegAddr.sv
// Shift register with an addressable tap; entry 0 is the newest word.
// Ports: clk_i, en_i (shift in data_i), addr_i (tap select), data_o (tap value).
// Holds data only: validity of the contents is tracked by the user.
module ShiftRegAddr #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4,
    parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [Width-1:0]  data_i,
    input  logic [AddrW-1:0]  addr_i,
    output logic [Width-1:0]  data_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[0] <= data_i;
            for (int i = 1; i < int'(Depth); i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign data_o = mem_q[addr_i];

endmodule

// File: rtl/border_cropper.sv
// Drops the first and last CropSize beats of every line of a line-framed
// stream of sample pairs, re-tagging sof/eol on the surviving beats.
// Ports:
//   clk_i, rst_ni    : clock, synchronous active-low reset
//   s (slave)        : input stream  (s.ready = input ready)
//   m (master)       : output stream (registered)
//   short_line_o     : one-cycle pulse after an eol arrives before any beat survived
// Build option: define BORDER_CROPPER_SHORT_LINE_DET_EN to build short-line
// detection; otherwise short_line_o is tied low (short lines are still dropped).
module border_cropper
    import dwt97_pkg::*;
#(
    parameter int unsigned DataWidth      = SampleWidth,
    parameter int unsigned CropSize       = ExpandSize,
    parameter int unsigned EnableInputReg = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    border_cropper_if.slave    s,
    border_cropper_if.master   m,
    output logic               short_line_o
);

    localparam int unsigned BeatW = 2 * DataWidth;
    localparam int unsigned BusW  = BeatW + 2;
    localparam int unsigned CntW  = $clog2(2 * CropSize + 1);
    localparam int unsigned AddrW = (CropSize > 1) ? $clog2(CropSize) : 1;
    localparam logic [AddrW-1:0] TapAddr  = AddrW'(CropSize - 1);
    localparam logic [CntW-1:0]  LeftLast = CntW'(CropSize - 1);
    localparam logic [CntW-1:0]  FillLast = CntW'(2 * CropSize - 1);

    crop_state_t       state_q;
    logic [CntW-1:0]   cnt_q;
    logic              need_sof_q;

    logic [BusW-1:0]   in_bus;
    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic              in_eol;
    logic [BeatW-1:0]  in_data;
    logic              in_hs;

    logic              core_valid;
    logic              core_ready;
    logic              push;
    logic [BeatW-1:0]  oldest;
    logic [BusW-1:0]   out_bus;

    // Optional input stage.
    AxisReg #(
        .Width  (BusW),
        .Enable (EnableInputReg != 0)
    ) u_in_reg (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .s_valid_i (s.valid),
        .s_ready_o (s.ready),
        .s_data_i  ({s.sof, s.eol, s.data}),
        .m_valid_o (in_valid),
        .m_ready_i (in_ready),
        .m_data_o  (in_bus)
    );

    assign in_sof  = in_bus[BusW-1];
    assign in_eol  = in_bus[BusW-2];
    assign in_data = in_bus[BeatW-1:0];

    // Border phases swallow input regardless of the sink; streaming is a joint handshake.
    always_comb begin
        in_ready   = 1'b1;
        core_valid = 1'b0;
        if (state_q == Stream) begin
            in_ready   = core_ready;
            core_valid = in_valid;
        end
    end

    assign in_hs = in_valid && in_ready;
    assign push  = in_hs && (state_q != DropLeft);

    // Delay line: its tail is the oldest kept beat, so the right border stays behind on eol.
    ShiftRegAddr #(
        .Width (BeatW),
        .Depth (CropSize),
        .AddrW (AddrW)
    ) u_delay (
        .clk_i  (clk_i),
        .en_i   (push),
        .data_i (in_data),
        .addr_i (TapAddr),
        .data_o (oldest)
    );

    // Output stage.
    AxisReg #(
        .Width  (BusW),
        .Enable (1'b1)
    ) u_out_reg (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .s_valid_i (core_valid),
        .s_ready_o (core_ready),
        .s_data_i  ({need_sof_q, in_eol, oldest}),
        .m_valid_o (m.valid),
        .m_ready_i (m.ready),
        .m_data_o  (out_bus)
    );

    assign m.sof  = out_bus[BusW-1];
    assign m.eol  = out_bus[BusW-2];
    assign m.data = out_bus[BeatW-1:0];

    // Line phase tracking; an eol before Stream resynchronises without emitting.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= DropLeft;
            cnt_q      <= '0;
            need_sof_q <= 1'b0;
        end else if (in_hs) begin
            unique case (state_q)
                DropLeft: begin
                    if (cnt_q == '0) begin
                        need_sof_q <= in_sof;
                    end
                    if (in_eol) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == LeftLast) begin
                            state_q <= Fill;
                        end
                    end
                end
                Fill: begin
                    if (in_eol) begin
                        cnt_q   <= '0;
                        state_q <= DropLeft;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == FillLast) begin
                            state_q <= Stream;
                        end
                    end
                end
                Stream: begin
                    need_sof_q <= 1'b0;
                    if (in_eol) begin
                        cnt_q   <= '0;
                        state_q <= DropLeft;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= DropLeft;
                end
            endcase
        end
    end

`ifdef BORDER_CROPPER_SHORT_LINE_DET_EN
    logic short_q;

    // Pulse for the eol of a line that never reached Stream.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            short_q <= 1'b0;
        end else begin
            short_q <= in_hs && in_eol && (state_q != Stream);
        end
    end

    assign short_line_o = short_q;
`else
    assign short_line_o = 1'b0;
`endif

endmodule

// File: tb/tb_border_cropper.sv
// Directed self-checking bench for border_cropper (CropSize=4, input register on).
module tb_border_cropper;
    import dwt97_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned CS = 4;

    logic clk;
    logic rst_n;
    logic short_line;

    border_cropper_if #(.DataWidth(DW)) s_if ();
    border_cropper_if #(.DataWidth(DW)) m_if ();

    border_cropper #(
        .DataWidth      (DW),
        .CropSize       (CS),
        .EnableInputReg (1)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .s            (s_if),
        .m            (m_if),
        .short_line_o (short_line)
    );

    int          n_cmp;
    int          n_err;
    int unsigned cyc;
    axis_t       out_q[$];
    int unsigned out_cyc[$];
    int unsigned hs_cyc[$];
    int          short_cnt;
    int          early_stall;
    int          stall_any;
    bit          toggle_ready;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Output monitor: a beat observed valid&ready at negedge transfers on the next edge.
    initial begin
        short_cnt = 0;
        forever begin
            @(negedge clk);
            if (m_if.valid === 1'b1 && m_if.ready === 1'b1) begin
                out_q.push_back('{sof: m_if.sof, eol: m_if.eol, data: m_if.data});
                out_cyc.push_back(cyc);
            end
            if (short_line === 1'b1) short_cnt++;
        end
    end

    // Sink readiness: constant 1 or toggling 1,0,1,0.
    initial begin
        m_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_ready) m_if.ready = ~m_if.ready;
            else              m_if.ready = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    task automatic clear_obs();
        out_q.delete();
        out_cyc.delete();
        hs_cyc.delete();
        short_cnt   = 0;
        early_stall = 0;
        stall_any   = 0;
    endtask

    task automatic idle(input int n);
        s_if.valid = 1'b0;
        s_if.sof   = 1'b0;
        s_if.eol   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit sof, input bit eol,
                             input int idx, output bit ok);
        s_if.valid = 1'b1;
        s_if.data  = d;
        s_if.sof   = sof;
        s_if.eol   = eol;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_if.ready === 1'b1) begin
                ok = 1'b1;
                hs_cyc.push_back(cyc);
            end else begin
                stall_any++;
                if (idx < int'(2 * CS)) early_stall++;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
    endtask

    task automatic send_line(input int base, input int n, input bit sof,
                             input bit gaps, input bit close_line);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_if.valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_beat(32'(base + i), sof && (i == 0), close_line && (i == n - 1), i, ok);
            n_cmp++;
            if (!ok) begin
                n_err++;
                $display("FAIL send_handshake beat=%0d got=no_ready expected=ready", i);
            end
        end
    endtask

    task automatic drain(input int exp_n);
        for (int t = 0; t < 300; t++) begin
            if (out_q.size() >= exp_n) break;
            @(posedge clk);
        end
        repeat (20) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        toggle_ready = 1'b0;
        s_if.valid   = 1'b0;
        s_if.sof     = 1'b0;
        s_if.eol     = 1'b0;
        s_if.data    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got=%b expected=0", m_if.valid); end
        n_cmp++; if (m_if.sof !== 1'b0) begin n_err++; $display("FAIL reset_m_sof got=%b expected=0", m_if.sof); end
        n_cmp++; if (m_if.eol !== 1'b0) begin n_err++; $display("FAIL reset_m_eol got=%b expected=0", m_if.eol); end
        n_cmp++; if (m_if.data !== 32'd0) begin n_err++; $display("FAIL reset_m_data got=%0h expected=0", m_if.data); end
        n_cmp++; if (short_line !== 1'b0) begin n_err++; $display("FAIL reset_short got=%b expected=0", short_line); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (s_if.ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got=%b expected=1", s_if.ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_line();
        axis_t exp;
        clear_obs();
        send_line(0, 16, 1'b1, 1'b0, 1'b1);
        idle(1);
        drain(8);
        n_cmp++; if (out_q.size() != 8) begin n_err++; $display("FAIL basic_count got=%0d expected=8", out_q.size()); end
        for (int k = 0; k < 8 && k < out_q.size(); k++) begin
            exp = '{sof: (k == 0), eol: (k == 7), data: 32'(4 + k)};
            n_cmp++;
            if (out_q[k] !== exp) begin
                n_err++;
                $display("FAIL basic_beat%0d got sof=%b eol=%b data=%0d expected sof=%b eol=%b data=%0d",
                         k, out_q[k].sof, out_q[k].eol, out_q[k].data, exp.sof, exp.eol, exp.data);
            end
        end
        if (out_cyc.size() > 0 && hs_cyc.size() > 8) begin
            n_cmp++;
            if (out_cyc[0] - hs_cyc[8] != 2) begin
                n_err++;
                $display("FAIL basic_latency got=%0d expected=2", out_cyc[0] - hs_cyc[8]);
            end
        end
    endtask

    task automatic test_backpressure();
        axis_t exp;
        clear_obs();
        toggle_ready = 1'b1;
        send_line(0, 16, 1'b1, 1'b1, 1'b1);
        idle(1);
        drain(8);
        toggle_ready = 1'b0;
        idle(2);
        n_cmp++; if (out_q.size() != 8) begin n_err++; $display("FAIL bp_count got=%0d expected=8", out_q.size()); end
        for (int k = 0; k < 8 && k < out_q.size(); k++) begin
            exp = '{sof: (k == 0), eol: (k == 7), data: 32'(4 + k)};
            n_cmp++;
            if (out_q[k] !== exp) begin
                n_err++;
                $display("FAIL bp_beat%0d got sof=%b eol=%b data=%0d expected sof=%b eol=%b data=%0d",
                         k, out_q[k].sof, out_q[k].eol, out_q[k].data, exp.sof, exp.eol, exp.data);
            end
        end
        n_cmp++; if (early_stall != 0) begin n_err++; $display("FAIL bp_border_stall got=%0d expected=0", early_stall); end
    endtask

    task automatic test_min_line();
        axis_t exp;
        clear_obs();
        send_line(0, 9, 1'b1, 1'b0, 1'b1);
        idle(1);
        drain(1);
        n_cmp++; if (out_q.size() != 1) begin n_err++; $display("FAIL min_count got=%0d expected=1", out_q.size()); end
        if (out_q.size() > 0) begin
            exp = '{sof: 1'b1, eol: 1'b1, data: 32'd4};
            n_cmp++;
            if (out_q[0] !== exp) begin
                n_err++;
                $display("FAIL min_beat got sof=%b eol=%b data=%0d expected sof=1 eol=1 data=4",
                         out_q[0].sof, out_q[0].eol, out_q[0].data);
            end
        end
    endtask

    task automatic test_short_line();
        axis_t exp;
        int    exp_short;
`ifdef BORDER_CROPPER_SHORT_LINE_DET_EN
        exp_short = 1;
`else
        exp_short = 0;
`endif
        clear_obs();
        send_line(50, 6, 1'b1, 1'b0, 1'b1);
        idle(1);
        drain(0);
        n_cmp++; if (out_q.size() != 0) begin n_err++; $display("FAIL short_count got=%0d expected=0", out_q.size()); end
        n_cmp++; if (short_cnt != exp_short) begin n_err++; $display("FAIL short_pulse got=%0d expected=%0d", short_cnt, exp_short); end
        clear_obs();
        send_line(100, 12, 1'b1, 1'b0, 1'b1);
        idle(1);
        drain(4);
        n_cmp++; if (out_q.size() != 4) begin n_err++; $display("FAIL recover_count got=%0d expected=4", out_q.size()); end
        for (int k = 0; k < 4 && k < out_q.size(); k++) begin
            exp = '{sof: (k == 0), eol: (k == 3), data: 32'(104 + k)};
            n_cmp++;
            if (out_q[k] !== exp) begin
                n_err++;
                $display("FAIL recover_beat%0d got sof=%b eol=%b data=%0d expected sof=%b eol=%b data=%0d",
                         k, out_q[k].sof, out_q[k].eol, out_q[k].data, exp.sof, exp.eol, exp.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        axis_t exp;
        clear_obs();
        send_line(0, 16, 1'b1, 1'b0, 1'b1);
        send_line(200, 16, 1'b0, 1'b0, 1'b1);
        idle(1);
        drain(16);
        n_cmp++; if (out_q.size() != 16) begin n_err++; $display("FAIL b2b_count got=%0d expected=16", out_q.size()); end
        for (int k = 0; k < 16 && k < out_q.size(); k++) begin
            if (k < 8) exp = '{sof: (k == 0), eol: (k == 7), data: 32'(4 + k)};
            else       exp = '{sof: 1'b0, eol: (k == 15), data: 32'(204 + k - 8)};
            n_cmp++;
            if (out_q[k] !== exp) begin
                n_err++;
                $display("FAIL b2b_beat%0d got sof=%b eol=%b data=%0d expected sof=%b eol=%b data=%0d",
                         k, out_q[k].sof, out_q[k].eol, out_q[k].data, exp.sof, exp.eol, exp.data);
            end
        end
        n_cmp++; if (stall_any != 0) begin n_err++; $display("FAIL b2b_bubble got=%0d expected=0", stall_any); end
    endtask

    task automatic test_reset_mid_line();
        axis_t exp;
        clear_obs();
        send_line(0, 7, 1'b1, 1'b0, 1'b0);
        s_if.valid = 1'b0;
        rst_n      = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_if.valid !== 1'b0) begin n_err++; $display("FAIL midrst_m_valid got=%b expected=0", m_if.valid); end
        @(posedge clk);
        #1;
        idle(10);
        n_cmp++; if (out_q.size() != 0) begin n_err++; $display("FAIL midrst_leak got=%0d expected=0", out_q.size()); end
        clear_obs();
        send_line(300, 16, 1'b1, 1'b0, 1'b1);
        idle(1);
        drain(8);
        n_cmp++; if (out_q.size() != 8) begin n_err++; $display("FAIL midrst_count got=%0d expected=8", out_q.size()); end
        for (int k = 0; k < 8 && k < out_q.size(); k++) begin
            exp = '{sof: (k == 0), eol: (k == 7), data: 32'(304 + k)};
            n_cmp++;
            if (out_q[k] !== exp) begin
                n_err++;
                $display("FAIL midrst_beat%0d got sof=%b eol=%b data=%0d expected sof=%b eol=%b data=%0d",
                         k, out_q[k].sof, out_q[k].eol, out_q[k].data, exp.sof, exp.eol, exp.data);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        early_stall = 0;
        stall_any   = 0;
        test_reset();
        test_basic_line();
        test_backpressure();
        test_min_line();
        test_short_line();
        test_back_to_back();
        test_reset_mid_line();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
